mem_access: RTL and testbench

- Memory-access stage placed directly downstream of the execute stage.
- Consumes the execute stage's register-write, memory-read and memory-write requests and drives a simple request/ready data-bus port.
- Extracts and sign- or zero-extends load data, then presents the writeback register and value to the writeback stage.
- Asserts STALL to freeze the execute stage while a memory operation is outstanding, and exports its registered result as a forwarding source.

---
 rtl/mem_access_if.sv | 30 +++
 rtl/mem_access.sv | 151 +++++++++++++++
 tb/tb_mem_access.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-bus port of the memory-access stage.
// Request/ready reads with a later RVALID; posted writes.
interface mem_access_if;
  logic        BUS_R_REQ;
  logic [31:0] BUS_R_ADDR;
  logic        BUS_R_READY;
  logic        BUS_R_RVALID;
  logic [31:0] BUS_R_RDATA;
  logic        BUS_W_REQ;
  logic [31:0] BUS_W_ADDR;
  logic [3:0]  BUS_W_STRB;
  logic [31:0] BUS_W_DATA;
  logic        BUS_W_READY;

  modport master (
    output BUS_R_REQ, BUS_R_ADDR,
    output BUS_W_REQ, BUS_W_ADDR,
    output BUS_W_STRB, BUS_W_DATA,
    input  BUS_R_READY, BUS_R_RVALID,
    input  BUS_R_RDATA, BUS_W_READY
  );

  modport slave (
    input  BUS_R_REQ, BUS_R_ADDR,
    input  BUS_W_REQ, BUS_W_ADDR,
    input  BUS_W_STRB, BUS_W_DATA,
    output BUS_R_READY, BUS_R_RVALID,
    output BUS_R_RDATA, BUS_W_READY
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on the data bus,
// extends load data and registers the writeback result.
module mem_access (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  REG_W_RD,
  input  logic [31:0] REG_W_DATA,
  input  logic        MEM_R_VALID,
  input  logic [4:0]  MEM_R_RD,
  input  logic [31:0] MEM_R_ADDR,
  input  logic [3:0]  MEM_R_STRB,
  input  logic        MEM_R_SIGNED,
  input  logic        MEM_W_VALID,
  input  logic [31:0] MEM_W_ADDR,
  input  logic [3:0]  MEM_W_STRB,
  input  logic [31:0] MEM_W_DATA,
  output logic        STALL,
  mem_access_if.master bus,
  output logic [4:0]  WB_RD,
  output logic [31:0] WB_DATA,
  output logic [4:0]  FWD_RD,
  output logic [31:0] FWD_V
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  logic [1:0]  state;
  logic [31:0] r_addr;
  logic [31:0] w_addr;
  logic [3:0]  w_strb;
  logic [31:0] w_data;
  logic [3:0]  ld_strb;
  logic        ld_sgn;
  logic [4:0]  ld_rd;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic [1:0]  lane;
  logic [2:0]  pc;
  logic [31:0] sh;
  logic [31:0] ld_val;
  logic        is_byte;
  logic        is_half;

  always_comb begin
    lane = 2'd0;
    unique case (1'b1)
      ld_strb[0]:             lane = 2'd0;
      ld_strb[1:0] == 2'b10:  lane = 2'd1;
      ld_strb[2:0] == 3'b100: lane = 2'd2;
      ld_strb == 4'b1000:     lane = 2'd3;
      default:                lane = 2'd0;
    endcase
  end

  // A half in the top lane cannot fit, so it degrades to a byte.
  always_comb begin
    pc = {2'b0, ld_strb[0]} + {2'b0, ld_strb[1]}
       + {2'b0, ld_strb[2]} + {2'b0, ld_strb[3]};
    sh = bus.BUS_R_RDATA >> {lane, 3'b000};
    is_byte = (pc == 3'd1)
            || (pc == 3'd2 && lane == 2'd3);
    is_half = (pc == 3'd2) && (lane != 2'd3);
    ld_val = sh;
    if (is_byte)
      ld_val = {{24{ld_sgn & sh[7]}}, sh[7:0]};
    else if (is_half)
      ld_val = {{16{ld_sgn & sh[15]}}, sh[15:0]};
  end

  always_comb begin
    STALL = 1'b0;
    unique case (state)
      IDLE:    STALL = MEM_W_VALID | MEM_R_VALID;
      RD_REQ:  STALL = 1'b1;
      RD_WAIT: STALL = ~bus.BUS_R_RVALID;
      WR_REQ:  STALL = ~bus.BUS_W_READY;
      default: STALL = 1'b0;
    endcase
    if (RST)
      STALL = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      r_addr  <= '0;
      w_addr  <= '0;
      w_strb  <= '0;
      w_data  <= '0;
      ld_strb <= '0;
      ld_sgn  <= 1'b0;
      ld_rd   <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_rd <= '0;
      unique case (state)
        IDLE: begin
          if (MEM_W_VALID) begin
            w_addr <= MEM_W_ADDR;
            w_strb <= MEM_W_STRB;
            w_data <= MEM_W_DATA;
            state  <= WR_REQ;
          end else if (MEM_R_VALID) begin
            r_addr  <= MEM_R_ADDR;
            ld_strb <= MEM_R_STRB;
            ld_sgn  <= MEM_R_SIGNED;
            ld_rd   <= MEM_R_RD;
            state   <= RD_REQ;
          end else begin
            wb_rd   <= REG_W_RD;
            wb_data <= REG_W_DATA;
          end
        end
        RD_REQ: begin
          if (bus.BUS_R_READY)
            state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.BUS_R_RVALID) begin
            wb_rd   <= ld_rd;
            wb_data <= ld_val;
            state   <= IDLE;
          end
        end
        WR_REQ: begin
          if (bus.BUS_W_READY)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUS_R_REQ  = (state == RD_REQ);
  assign bus.BUS_R_ADDR = r_addr;
  assign bus.BUS_W_REQ  = (state == WR_REQ);
  assign bus.BUS_W_ADDR = w_addr;
  assign bus.BUS_W_STRB = w_strb;
  assign bus.BUS_W_DATA = w_data;

  assign WB_RD   = wb_rd;
  assign WB_DATA = wb_data;
  assign FWD_RD  = wb_rd;
  assign FWD_V   = wb_data;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a
// transaction-level timing and load-extension model.
module tb_mem_access;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  REG_W_RD;
  logic [31:0] REG_W_DATA;
  logic        MEM_R_VALID;
  logic [4:0]  MEM_R_RD;
  logic [31:0] MEM_R_ADDR;
  logic [3:0]  MEM_R_STRB;
  logic        MEM_R_SIGNED;
  logic        MEM_W_VALID;
  logic [31:0] MEM_W_ADDR;
  logic [3:0]  MEM_W_STRB;
  logic [31:0] MEM_W_DATA;
  logic        STALL;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic [4:0]  FWD_RD;
  logic [31:0] FWD_V;

  mem_access_if bus ();

  mem_access dut (
    .CLK          (CLK),
    .RST          (RST),
    .REG_W_RD     (REG_W_RD),
    .REG_W_DATA   (REG_W_DATA),
    .MEM_R_VALID  (MEM_R_VALID),
    .MEM_R_RD     (MEM_R_RD),
    .MEM_R_ADDR   (MEM_R_ADDR),
    .MEM_R_STRB   (MEM_R_STRB),
    .MEM_R_SIGNED (MEM_R_SIGNED),
    .MEM_W_VALID  (MEM_W_VALID),
    .MEM_W_ADDR   (MEM_W_ADDR),
    .MEM_W_STRB   (MEM_W_STRB),
    .MEM_W_DATA   (MEM_W_DATA),
    .STALL        (STALL),
    .bus          (bus),
    .WB_RD        (WB_RD),
    .WB_DATA      (WB_DATA),
    .FWD_RD       (FWD_RD),
    .FWD_V        (FWD_V)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_rreq, exp_wreq;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        exp_dv;
  logic [31:0] exp_raddr, exp_waddr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [4:0]  cur_rd;
  logic [31:0] cur_data;
  logic        cur_dv;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h at %0t",
               nm, act, req, $time);
    end
  endtask

  // Load result from strobe rules: lowest lane, size by popcount.
  function automatic logic [31:0] ref_ext(
      input logic [3:0] s, input logic sg,
      input logic [31:0] d);
    int lane;
    int nb;
    int cnt;
    logic [31:0] v;
    logic [31:0] m;
    lane = 0;
    for (int i = 3; i >= 0; i--)
      if (s[i]) lane = i;
    cnt = $countones(s);
    if (cnt == 1) nb = 1;
    else if (cnt == 2) nb = (lane == 3) ? 1 : 2;
    else nb = 4;
    v = d >> (8 * lane);
    if (nb < 4) begin
      m = (32'd1 << (8 * nb)) - 32'd1;
      v = v & m;
      if (sg && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      cmp("STALL", 32'(STALL), 32'(exp_stall));
      cmp("BUS_R_REQ", 32'(bus.BUS_R_REQ), 32'(exp_rreq));
      cmp("BUS_W_REQ", 32'(bus.BUS_W_REQ), 32'(exp_wreq));
      cmp("WB_RD", 32'(WB_RD), 32'(exp_rd));
      cmp("FWD_RD", 32'(FWD_RD), 32'(exp_rd));
      if (exp_dv) begin
        cmp("WB_DATA", WB_DATA, exp_data);
        cmp("FWD_V", FWD_V, exp_data);
      end
      if (exp_rreq)
        cmp("BUS_R_ADDR", bus.BUS_R_ADDR, exp_raddr);
      if (exp_wreq) begin
        cmp("BUS_W_ADDR", bus.BUS_W_ADDR, exp_waddr);
        cmp("BUS_W_STRB", 32'(bus.BUS_W_STRB),
            32'(exp_wstrb));
        cmp("BUS_W_DATA", bus.BUS_W_DATA, exp_wdata);
      end
    end
  end

  // One clock of the schedule; nrd/nd/ndv is WB after this edge.
  task automatic step(input logic s, input logic rr,
                      input logic wr, input logic [4:0] nrd,
                      input logic [31:0] nd, input logic ndv);
    exp_stall = s;
    exp_rreq  = rr;
    exp_wreq  = wr;
    exp_rd    = cur_rd;
    exp_data  = cur_data;
    exp_dv    = cur_dv;
    @(posedge CLK);
    #1;
    cur_rd   = nrd;
    cur_data = nd;
    cur_dv   = ndv;
  endtask

  task automatic idle_bus();
    bus.BUS_R_READY  = 1'($urandom);
    bus.BUS_R_RVALID = 1'($urandom);
    bus.BUS_W_READY  = 1'($urandom);
    bus.BUS_R_RDATA  = $urandom;
  endtask

  task automatic do_alu(input logic [4:0] rd,
                        input logic [31:0] d);
    MEM_W_VALID = 1'b0;
    MEM_R_VALID = 1'b0;
    REG_W_RD    = rd;
    REG_W_DATA  = d;
    idle_bus();
    step(1'b0, 1'b0, 1'b0, rd, d, 1'b1);
  endtask

  task automatic do_load(input logic [4:0] rd,
                         input logic [31:0] a,
                         input logic [3:0] s, input logic sg,
                         input int d1, input int d2,
                         input logic [31:0] rdata,
                         input logic [31:0] ev);
    MEM_W_VALID  = 1'b0;
    MEM_R_VALID  = 1'b1;
    MEM_R_RD     = rd;
    MEM_R_ADDR   = a;
    MEM_R_STRB   = s;
    MEM_R_SIGNED = sg;
    REG_W_RD     = 5'($urandom);
    REG_W_DATA   = $urandom;
    exp_raddr    = a;
    idle_bus();
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 0; k <= d1; k++) begin
      bus.BUS_R_READY  = (k == d1);
      bus.BUS_R_RVALID = (k != d1) && 1'($urandom);
      bus.BUS_W_READY  = 1'($urandom);
      step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    end
    for (int j = 0; j <= d2; j++) begin
      bus.BUS_R_RVALID = (j == d2);
      bus.BUS_R_READY  = 1'($urandom);
      bus.BUS_W_READY  = 1'($urandom);
      bus.BUS_R_RDATA  = (j == d2) ? rdata : $urandom;
      if (j == d2)
        step(1'b0, 1'b0, 1'b0, rd, ev, rd != 5'd0);
      else
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    end
  endtask

  task automatic do_store(input logic [31:0] a,
                          input logic [3:0] s,
                          input logic [31:0] d,
                          input int dl, input logic rv);
    MEM_W_VALID  = 1'b1;
    MEM_W_ADDR   = a;
    MEM_W_STRB   = s;
    MEM_W_DATA   = d;
    MEM_R_VALID  = rv;
    MEM_R_RD     = 5'd0;
    MEM_R_ADDR   = $urandom;
    MEM_R_STRB   = 4'($urandom);
    REG_W_RD     = 5'($urandom);
    exp_waddr    = a;
    exp_wstrb    = s;
    exp_wdata    = d;
    idle_bus();
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 0; k <= dl; k++) begin
      bus.BUS_W_READY  = (k == dl);
      bus.BUS_R_READY  = 1'($urandom);
      bus.BUS_R_RVALID = 1'($urandom);
      step(k != dl, 1'b0, 1'b1, 5'd0, 32'd0, 1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_STALL"}, 32'(STALL), 32'd0);
    cmp({tag, "_R_REQ"}, 32'(bus.BUS_R_REQ), 32'd0);
    cmp({tag, "_R_ADDR"}, bus.BUS_R_ADDR, 32'd0);
    cmp({tag, "_W_REQ"}, 32'(bus.BUS_W_REQ), 32'd0);
    cmp({tag, "_W_ADDR"}, bus.BUS_W_ADDR, 32'd0);
    cmp({tag, "_W_STRB"}, 32'(bus.BUS_W_STRB), 32'd0);
    cmp({tag, "_W_DATA"}, bus.BUS_W_DATA, 32'd0);
    cmp({tag, "_WB_RD"}, 32'(WB_RD), 32'd0);
    cmp({tag, "_WB_DATA"}, WB_DATA, 32'd0);
    cmp({tag, "_FWD_V"}, FWD_V, 32'd0);
  endtask

  logic [3:0] strbs [8] = '{4'b0001, 4'b0010, 4'b0100,
                            4'b1000, 4'b0011, 4'b1100,
                            4'b1111, 4'b0110};

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    REG_W_RD = 5'd0;
    REG_W_DATA = 32'd0;
    MEM_R_VALID = 1'b1;
    MEM_R_RD = 5'd1;
    MEM_R_ADDR = 32'h10;
    MEM_R_STRB = 4'hf;
    MEM_R_SIGNED = 1'b0;
    MEM_W_VALID = 1'b0;
    MEM_W_ADDR = 32'd0;
    MEM_W_STRB = 4'd0;
    MEM_W_DATA = 32'd0;
    bus.BUS_R_READY = 1'b0;
    bus.BUS_R_RVALID = 1'b0;
    bus.BUS_R_RDATA = 32'd0;
    bus.BUS_W_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_zero("reset");

    cmp("model_lb", ref_ext(4'b1000, 1'b1, 32'h80FF_FFFF),
        32'hFFFF_FF80);
    cmp("model_lhu", ref_ext(4'b1100, 1'b0, 32'hBEEF_0000),
        32'h0000_BEEF);

    RST = 1'b0;
    cur_rd = 5'd0;
    cur_data = 32'd0;
    cur_dv = 1'b1;
    chk_en = 1'b1;

    do_alu(5'd5, 32'h1234);
    do_load(5'd3, 32'h100, 4'b1111, 1'b0, 0, 0,
            32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load(5'd4, 32'h104, 4'b1000, 1'b1, 0, 0,
            32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load(5'd6, 32'h108, 4'b1100, 1'b0, 1, 2,
            32'hBEEF_0000, 32'h0000_BEEF);
    do_store(32'h40, 4'b0011, 32'hAABB, 3, 1'b1);
    do_load(5'd0, 32'h44, 4'b0001, 1'b1, 0, 1,
            32'h0000_0080, 32'hFFFF_FF80);
    do_alu(5'd7, 32'hCAFE_0001);

    // Reset while waiting for read data, then a stale RVALID.
    MEM_W_VALID  = 1'b0;
    MEM_R_VALID  = 1'b1;
    MEM_R_RD     = 5'd9;
    MEM_R_ADDR   = 32'h200;
    MEM_R_STRB   = 4'hf;
    exp_raddr    = 32'h200;
    idle_bus();
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    bus.BUS_R_READY  = 1'b1;
    bus.BUS_R_RVALID = 1'b0;
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    bus.BUS_R_READY  = 1'b0;
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk_zero("midreset");
    RST = 1'b0;
    MEM_R_VALID = 1'b0;
    REG_W_RD = 5'd0;
    REG_W_DATA = 32'h1357_9BDF;
    bus.BUS_R_RVALID = 1'b1;
    bus.BUS_R_RDATA = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h1357_9BDF, 1'b1);
    do_alu(5'd9, 32'h5555);

    for (int n = 0; n < 400; n++) begin
      int kind;
      logic [3:0] s;
      logic sg;
      logic [31:0] rd_data;
      logic [4:0] rd;
      kind = $urandom_range(0, 3);
      rd = 5'($urandom);
      if (kind < 2) begin
        do_alu(rd, $urandom);
      end else if (kind == 2) begin
        s = strbs[$urandom_range(0, 7)];
        sg = 1'($urandom);
        rd_data = $urandom;
        do_load(rd, {$urandom, 2'b00} >> 2 << 2, s, sg,
                $urandom_range(0, 3), $urandom_range(0, 3),
                rd_data, ref_ext(s, sg, rd_data));
      end else begin
        do_store($urandom & 32'hFFFF_FFFC, 4'($urandom),
                 $urandom, $urandom_range(0, 3),
                 1'($urandom));
      end
    end

    do_alu(5'd0, 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
